// File: rtl/pool_seq_ctrl_if.sv
// Control/status bundle between the pooling sequencer and its environment.
// master = sequencer side, slave = the controller/mux side that drives start and config.
interface pool_seq_ctrl_if #(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned DIM_W  = 8
);
    logic              start;
    logic              abort;
    logic              src_sel;
    logic [DIM_W-1:0]  rows;
    logic [DIM_W-1:0]  cols;
    logic [ADDR_W-1:0] src_base;
    logic [ADDR_W-1:0] dst_base;

    logic              busy;
    logic              done;
    logic              buf1_r_en;
    logic              buf1_w_en;
    logic              buf2_r_en;
    logic              buf2_w_en;
    logic [ADDR_W-1:0] buf1_r_addr;
    logic [ADDR_W-1:0] buf1_w_addr;
    logic [ADDR_W-1:0] buf2_r_addr;
    logic [ADDR_W-1:0] buf2_w_addr;
    logic [1:0]        aybz_azby_pool;
    logic              pool_enable;
    logic              shifting_line_pool;
    logic              line_buffer_reset_pool;
    logic [DIM_W-1:0]  row_length_pool;

    modport master (
        input  start, abort, src_sel, rows, cols, src_base, dst_base,
        output busy, done,
        output buf1_r_en, buf1_w_en, buf2_r_en, buf2_w_en,
        output buf1_r_addr, buf1_w_addr, buf2_r_addr, buf2_w_addr,
        output aybz_azby_pool, pool_enable, shifting_line_pool,
        output line_buffer_reset_pool, row_length_pool
    );

    modport slave (
        output start, abort, src_sel, rows, cols, src_base, dst_base,
        input  busy, done,
        input  buf1_r_en, buf1_w_en, buf2_r_en, buf2_w_en,
        input  buf1_r_addr, buf1_w_addr, buf2_r_addr, buf2_w_addr,
        input  aybz_azby_pool, pool_enable, shifting_line_pool,
        input  line_buffer_reset_pool, row_length_pool
    );
endinterface

// File: rtl/pool_seq_ctrl.sv
// Pooling-layer sequencer: streams a feature map from the source buffer into the PE-array
// pool line buffer and writes each 2x2 max-pool result into the opposite buffer.
module pool_seq_ctrl #(
    parameter int unsigned ADDR_W  = 10,
    parameter int unsigned DIM_W   = 8,
    parameter int unsigned PEA_LAT = 2
) (
    input logic             clk,
    input logic             rst_n,
    pool_seq_ctrl_if.master bus
);
    localparam int unsigned DlyLen = PEA_LAT + 1;
    localparam int unsigned DrainW = $clog2(PEA_LAT + 2);

    typedef enum logic [2:0] {StIdle, StLbrst, StRead, StDrain, StDone} state_e;

    state_e state_q, state_d;

    logic [DIM_W-1:0]  rows_q, cols_q;
    logic [ADDR_W-1:0] src_base_q, dst_base_q;
    logic              src_sel_q;
    logic [DIM_W-1:0]  r_q, c_q;
    logic [ADDR_W-1:0] rd_addr_q;
    logic [ADDR_W-1:0] wr_cnt_q;
    logic [DrainW-1:0] drain_q;
    logic [DlyLen-1:0] tag_dly_q;
    logic              rd_dly_q;

    logic              start_acc;
    logic              col_last;
    logic              last_read;
    logic              rd_en;
    logic              wr_en;
    logic              busy;
    logic [ADDR_W-1:0] wr_addr;

    // Next-state logic; abort overrides every transition, including a same-cycle start.
    always_comb begin
        state_d   = state_q;
        start_acc = 1'b0;
        col_last  = (c_q == cols_q - DIM_W'(1));
        last_read = col_last && (r_q == rows_q - DIM_W'(1));
        unique case (state_q)
            StIdle: begin
                if (bus.start && !bus.abort) begin
                    state_d   = StLbrst;
                    start_acc = 1'b1;
                end
            end
            StLbrst: begin
                state_d = (rows_q == '0 || cols_q == '0) ? StDrain : StRead;
            end
            StRead: begin
                if (last_read) state_d = StDrain;
            end
            StDrain: begin
                if (drain_q == DrainW'(PEA_LAT)) state_d = StDone;
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
        if (bus.abort) state_d = StIdle;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= StIdle;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rows_q     <= '0;
            cols_q     <= '0;
            src_base_q <= '0;
            dst_base_q <= '0;
            src_sel_q  <= 1'b0;
            r_q        <= '0;
            c_q        <= '0;
            rd_addr_q  <= '0;
            wr_cnt_q   <= '0;
            drain_q    <= '0;
            tag_dly_q  <= '0;
            rd_dly_q   <= 1'b0;
        end else begin
            if (start_acc) begin
                rows_q     <= bus.rows;
                cols_q     <= bus.cols;
                src_base_q <= bus.src_base;
                dst_base_q <= bus.dst_base;
                src_sel_q  <= bus.src_sel;
                r_q        <= '0;
                c_q        <= '0;
                rd_addr_q  <= bus.src_base;
            end else if (rd_en) begin
                // Row-major walk: the linear address simply increments, r/c only feed the tag.
                rd_addr_q <= rd_addr_q + ADDR_W'(1);
                if (col_last) begin
                    c_q <= '0;
                    r_q <= r_q + DIM_W'(1);
                end else begin
                    c_q <= c_q + DIM_W'(1);
                end
            end

            if (start_acc)  wr_cnt_q <= '0;
            else if (wr_en) wr_cnt_q <= wr_cnt_q + ADDR_W'(1);

            drain_q <= (state_q == StDrain) ? drain_q + DrainW'(1) : '0;

            // A pixel with odd row and odd column closes a 2x2 window.
            if (bus.abort) begin
                tag_dly_q <= '0;
                rd_dly_q  <= 1'b0;
            end else begin
                tag_dly_q <= (tag_dly_q << 1) | DlyLen'(rd_en & r_q[0] & c_q[0]);
                rd_dly_q  <= rd_en;
            end
        end
    end

    always_comb begin
        busy    = (state_q != StIdle);
        rd_en   = (state_q == StRead);
        wr_en   = tag_dly_q[DlyLen-1];
        wr_addr = dst_base_q + wr_cnt_q;

        bus.busy                   = busy;
        bus.done                   = (state_q == StDone);
        bus.pool_enable            = (state_q == StLbrst) || (state_q == StRead)
                                     || (state_q == StDrain);
        bus.line_buffer_reset_pool = (state_q == StLbrst);
        bus.shifting_line_pool     = rd_dly_q;
        bus.row_length_pool        = busy ? cols_q : '0;
        bus.aybz_azby_pool         = (busy && !src_sel_q) ? 2'b01 : 2'b00;

        bus.buf1_r_en   = rd_en & ~src_sel_q;
        bus.buf2_r_en   = rd_en & src_sel_q;
        bus.buf1_w_en   = wr_en & src_sel_q;
        bus.buf2_w_en   = wr_en & ~src_sel_q;
        bus.buf1_r_addr = bus.buf1_r_en ? rd_addr_q : '0;
        bus.buf2_r_addr = bus.buf2_r_en ? rd_addr_q : '0;
        bus.buf1_w_addr = bus.buf1_w_en ? wr_addr : '0;
        bus.buf2_w_addr = bus.buf2_w_en ? wr_addr : '0;
    end
endmodule

// File: tb/tb_pool_seq_ctrl.sv
// Directed bench for pool_seq_ctrl: vector table of jobs with a per-cycle reference model,
// plus hand-written sequences for start/abort collision, async reset and exact 4x4 timing.
module tb_pool_seq_ctrl;
    localparam int LAT = 2;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    pool_seq_ctrl_if #(.ADDR_W(10), .DIM_W(8)) bus ();

    pool_seq_ctrl #(.ADDR_W(10), .DIM_W(8), .PEA_LAT(LAT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int rows;
        int cols;
        bit sel;
        int sb;
        int db;
        int abort_at;
        int poke_at;
        int exp_reads;
        int exp_writes;
        int exp_done;
    } vec_t;

    vec_t vecs[9];
    int   wr_cycs[$];
    int   wr_addrs[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] all_outs();
        return 64'({bus.busy, bus.done, bus.buf1_r_en, bus.buf1_w_en, bus.buf2_r_en,
                    bus.buf2_w_en, bus.buf1_r_addr, bus.buf1_w_addr, bus.buf2_r_addr,
                    bus.buf2_w_addr, bus.aybz_azby_pool, bus.pool_enable,
                    bus.shifting_line_pool, bus.line_buffer_reset_pool, bus.row_length_pool});
    endfunction

    task automatic drive_cfg(input vec_t v);
        bus.rows     = 8'(v.rows);
        bus.cols     = 8'(v.cols);
        bus.src_sel  = v.sel;
        bus.src_base = 10'(v.sb);
        bus.dst_base = 10'(v.db);
    endtask

    task automatic run_job(input int vi, input vec_t v);
        int n, done_c, last, widx, wcnt, nrd, nwr, dcyc;
        bit aborted, alive, e_busy, e_done, e_rd, e_wr, e_sh, a_wr;
        logic [9:0] e_raddr, e_waddr, a_src, a_oth, a_dst, a_woth;
        logic [1:0] e_aybz;
        logic [7:0] e_rlen;
        n       = (v.rows == 0 || v.cols == 0) ? 0 : v.rows * v.cols;
        done_c  = n + LAT + 3;
        aborted = (v.abort_at != 0) && (v.abort_at < done_c);
        last    = aborted ? v.abort_at + 3 : done_c + 2;
        wcnt = 0; nrd = 0; nwr = 0; dcyc = 0;
        wr_cycs.delete();
        wr_addrs.delete();

        @(negedge clk);
        drive_cfg(v);
        bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;

        for (int t = 1; t <= last; t++) begin
            @(negedge clk);
            if (t == v.abort_at + 1) bus.abort = 1'b0;
            if (t == v.poke_at + 1) bus.start = 1'b0;
            alive   = aborted ? (t <= v.abort_at) : (t <= done_c);
            e_busy  = alive;
            e_done  = !aborted && (t == done_c);
            e_rd    = alive && (t >= 2) && (t <= n + 1);
            e_sh    = alive && (t >= 3) && (t <= n + 2);
            e_raddr = 10'(v.sb + t - 2);
            widx    = t - 3 - LAT;
            e_wr    = alive && (widx >= 0) && (widx < n)
                      && ((widx / v.cols) % 2 == 1) && ((widx % v.cols) % 2 == 1);
            e_waddr = 10'(v.db + wcnt);
            e_aybz  = (e_busy && !v.sel) ? 2'b01 : 2'b00;
            e_rlen  = e_busy ? 8'(v.cols) : 8'd0;

            check($sformatf("j%0d_c%0d_ctrl", vi, t),
                  64'({bus.busy, bus.done, bus.pool_enable, bus.shifting_line_pool,
                       bus.line_buffer_reset_pool, bus.aybz_azby_pool, bus.row_length_pool}),
                  64'({e_busy, e_done, e_busy && (t < done_c), e_sh,
                       alive && (t == 1), e_aybz, e_rlen}));

            a_src  = v.sel ? bus.buf2_r_addr : bus.buf1_r_addr;
            a_oth  = v.sel ? bus.buf1_r_addr : bus.buf2_r_addr;
            check($sformatf("j%0d_c%0d_rd", vi, t),
                  64'({bus.buf1_r_en, bus.buf2_r_en, e_rd ? a_src : 10'd0, a_oth}),
                  64'({e_rd & ~v.sel, e_rd & v.sel, e_rd ? e_raddr : 10'd0, 10'd0}));

            a_dst  = v.sel ? bus.buf1_w_addr : bus.buf2_w_addr;
            a_woth = v.sel ? bus.buf2_w_addr : bus.buf1_w_addr;
            check($sformatf("j%0d_c%0d_wr", vi, t),
                  64'({bus.buf1_w_en, bus.buf2_w_en, e_wr ? a_dst : 10'd0, a_woth}),
                  64'({e_wr & v.sel, e_wr & ~v.sel, e_wr ? e_waddr : 10'd0, 10'd0}));

            if (e_wr) wcnt++;
            if (bus.buf1_r_en || bus.buf2_r_en) nrd++;
            a_wr = bus.buf1_w_en || bus.buf2_w_en;
            if (a_wr) begin
                nwr++;
                wr_cycs.push_back(t);
                wr_addrs.push_back(int'(a_dst));
            end
            if (bus.done) dcyc = t;

            if (t == v.abort_at) bus.abort = 1'b1;
            if (t == v.poke_at) begin
                // Start with a different config while busy must be ignored.
                bus.start   = 1'b1;
                bus.rows    = 8'd9;
                bus.cols    = 8'd9;
                bus.src_sel = ~v.sel;
            end
        end
        bus.abort = 1'b0;
        bus.start = 1'b0;
        check($sformatf("j%0d_reads", vi), 64'(nrd), 64'(v.exp_reads));
        check($sformatf("j%0d_writes", vi), 64'(nwr), 64'(v.exp_writes));
        check($sformatf("j%0d_done_cycle", vi), 64'(dcyc), 64'(v.exp_done));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_wc[4];
        int exp_wa[4];
        vec_t v44;
        checks   = 0;
        failures = 0;
        exp_wc   = '{10, 12, 18, 20};
        exp_wa   = '{'h40, 'h41, 'h42, 'h43};

        //            rows cols sel  sb     db    abrt poke rd  wr  done
        vecs[0] = '{4, 4, 1'b0, 'h10,  'h40,  0, 0, 16, 4, 21};
        vecs[1] = '{5, 3, 1'b1, 'h20,  'h100, 0, 0, 15, 2, 20};
        vecs[2] = '{1, 8, 1'b0, 'h000, 'h200, 0, 0, 8,  0, 13};
        vecs[3] = '{0, 5, 1'b1, 'h50,  'h60,  0, 0, 0,  0, 5};
        vecs[4] = '{2, 2, 1'b0, 'h3FE, 'h80,  0, 3, 4,  1, 9};
        vecs[5] = '{4, 4, 1'b0, 'h10,  'h40,  8, 0, 7,  0, 0};
        vecs[6] = '{4, 4, 1'b0, 'h10,  'h40,  0, 0, 16, 4, 21};
        vecs[7] = '{3, 5, 1'b1, 'h3F0, 'h3FF, 0, 0, 15, 2, 20};
        vecs[8] = '{4, 0, 1'b0, 'h10,  'h20,  0, 5, 0,  0, 5};
        v44 = vecs[0];

        rst_n        = 1'b0;
        bus.start    = 1'b0;
        bus.abort    = 1'b0;
        bus.src_sel  = 1'b0;
        bus.rows     = '0;
        bus.cols     = '0;
        bus.src_base = '0;
        bus.dst_base = '0;
        #1 check("reset_state", all_outs(), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 9; i++) run_job(i, vecs[i]);

        // Start and abort in the same idle cycle: abort wins.
        @(negedge clk);
        drive_cfg(v44);
        bus.start = 1'b1;
        bus.abort = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check($sformatf("start_abort_idle_%0d", k), 64'(bus.busy), 64'd0);
        end

        // Asynchronous reset in the middle of READ, checked between clock edges.
        @(negedge clk);
        drive_cfg(v44);
        bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (6) @(negedge clk);
        check("pre_rst_reading", 64'(bus.buf1_r_en), 64'd1);
        #2 rst_n = 1'b0;
        #1 check("async_rst_outs", all_outs(), 64'd0);
        @(negedge clk);
        check("rst_held_outs", all_outs(), 64'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("post_rst_idle", 64'(bus.busy), 64'd0);

        // Exact 4x4 write timing and addresses after reset.
        run_job(9, v44);
        check("w4x4_count", 64'(wr_cycs.size()), 64'd4);
        for (int k = 0; k < 4 && k < wr_cycs.size(); k++) begin
            check($sformatf("w4x4_cycle_%0d", k), 64'(wr_cycs[k]), 64'(exp_wc[k]));
            check($sformatf("w4x4_addr_%0d", k), 64'(wr_addrs[k]), 64'(exp_wa[k]));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/pool_seq_ctrl.md
Name: pool_seq_ctrl

Overview:
- Pooling-layer sequencer that drives the pool-side control inputs of the buffer-to-PE-array mux: m1 buffer read/write controls, PE-array pool controls and the ping-pong direction code.
- Streams one feature map row-major out of the source buffer into the PE-array pool line buffer.
- Writes each 2x2 stride-2 max-pool result from the PE array into the opposite buffer.
- Active only while the top-level compute select is POOL; the mux ignores its outputs otherwise.

Parameters:
- ADDR_W, 10, buffer m1 address width; addresses are broadcast to all banks in the parent.
- DIM_W, 8, width of the rows and cols configuration fields.
- PEA_LAT, 2, cycles from shifting_line_pool high to the matching pooled word on the PE-array output.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle start pulse; honoured only in IDLE.
- abort  in  1  synchronous abort; returns to IDLE without a done pulse.
- src_sel  in  1  source buffer select: 0 = buf1 source / buf2 destination, 1 = buf2 source / buf1 destination.
- rows  in  DIM_W  input feature-map rows; sampled at start.
- cols  in  DIM_W  input feature-map columns; sampled at start.
- src_base  in  ADDR_W  first read address; sampled at start.
- dst_base  in  ADDR_W  first write address; sampled at start.
- busy  out  1  high whenever state is not IDLE.
- done  out  1  one-cycle completion pulse.
- buf1_r_en, buf1_w_en, buf2_r_en, buf2_w_en  out  1 each  m1 read/write enables.
- buf1_r_addr, buf1_w_addr, buf2_r_addr, buf2_w_addr  out  ADDR_W each  m1 read/write addresses.
- aybz_azby_pool  out  2  2'b01 when src_sel = 0, 2'b00 when src_sel = 1.
- pool_enable  out  1  PE-array pool enable.
- shifting_line_pool  out  1  pixel-valid strobe into the pool line buffer.
- line_buffer_reset_pool  out  1  clears the pool line buffer.
- row_length_pool  out  DIM_W  latched cols value.

Behaviour:
- Reset (rst_n low, asynchronous): every output 0, state IDLE, all counters and the delay line cleared.
- Configuration: rows, cols, bases and src_sel are latched on the accepted start edge and held constant until IDLE.
- start while busy: ignored.
- FSM transitions:
  - IDLE -> LBRST on start.
  - LBRST lasts 1 cycle: line_buffer_reset_pool = 1.
  - LBRST -> READ.
  - READ lasts rows*cols cycles; source r_en = 1 each cycle.
  - READ -> DRAIN after the last read; DRAIN lasts PEA_LAT+1 cycles.
  - DRAIN -> DONE; DONE lasts 1 cycle with done = 1.
  - DONE -> IDLE.
- If rows = 0 or cols = 0: LBRST goes directly to DRAIN with no reads and no writes; done still pulses.
- Read addressing: r_addr = src_base + r*cols + c, with c incrementing fastest. Address arithmetic is modulo 2^ADDR_W.
- Buffer read latency is 1 cycle, so shifting_line_pool is r_en delayed by 1 cycle.
- pool_enable = 1 in LBRST, READ and DRAIN; 0 otherwise. row_length_pool = latched cols while busy, 0 in IDLE.
- Emit tag: a pixel is tagged when r and c are both odd. The tag travels a (1 + PEA_LAT)-stage delay line alongside the read.
- Write side: destination w_en = delayed tag. w_addr = dst_base + k, where k counts emitted words from 0 and wraps modulo 2^ADDR_W.
- Writes produced = floor(rows/2) * floor(cols/2). A trailing odd row or column is read but produces no output.
- Exclusivity: non-source r_en = 0 and non-destination w_en = 0 at all times; unused addresses are held at 0.
- Abort: FSM goes to IDLE next cycle and the delay line is flushed. Writes in flight are dropped, no done pulse, all outputs return to 0.
- Abort on the same cycle as start in IDLE: abort wins; remain in IDLE.

Test Plan:
- 4x4, src_sel=0, src_base=0x10, dst_base=0x40, PEA_LAT=2, start sampled at edge 0 -> LBRST at cycle 1; buf1_r_en at cycles 2..17, addresses 0x10..0x1F; buf2_w_en at cycles 10, 12, 18, 20 with addresses 0x40..0x43; done at cycle 21; busy at cycles 1..21; aybz_azby_pool = 01.
- 5x3, src_sel=1 -> 15 reads from buf2; 2 writes into buf1 (from pixels (1,1) and (3,1)); aybz_azby_pool = 00; buf1_r_en and buf2_w_en stay 0 throughout.
- rows=1, cols=8 -> 8 reads, 0 writes, done pulses; rows=0 -> 0 reads, done at cycle 1+1+PEA_LAT+1.
- src_base=0x3FE, 2x2 -> read addresses 0x3FE, 0x3FF, 0x000, 0x001 (wrap); exactly one write.
- abort asserted at cycle 8 of the 4x4 case -> IDLE at cycle 9; the write due at cycle 10 is dropped; no done pulse; a second start then completes normally.
- rst_n asserted low mid-READ -> all outputs 0 immediately, without a clock edge; start pulses during busy produce no restart.
